// File: rtl/eth_port_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | eth_port_tx_if : host stream + switch port bundle for eth_port_tx   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface eth_port_tx_if;
  logic [31:0] host_data;
  logic        host_valid;
  logic        host_last;
  logic        host_ready;
  logic [31:0] tx_data;
  logic        tx_sop;
  logic        tx_eop;
  logic        tx_stall;
  logic [15:0] tx_pkt_cnt;
  logic        err_runt;
  logic        err_oversize;

  modport master (
    output host_data, host_valid, host_last, tx_stall,
    input  host_ready, tx_data, tx_sop, tx_eop, tx_pkt_cnt, err_runt, err_oversize
  );

  modport slave (
    input  host_data, host_valid, host_last, tx_stall,
    output host_ready, tx_data, tx_sop, tx_eop, tx_pkt_cnt, err_runt, err_oversize
  );
endinterface
`default_nettype wire

// File: rtl/eth_port_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | eth_port_tx : store-and-forward packet transmitter for one switch  |
// | ingress port. Rev 1.0                                              |
// +--------------------------------------------------------------------+
module eth_port_tx #(
  parameter int FIFO_DEPTH    = 64,
  parameter int MAX_PKT_WORDS = 32,
  parameter int IPG_CYCLES    = 1
) (
  input  logic         clk,
  input  logic         reset,
  eth_port_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(MAX_PKT_WORDS) + 1;
  localparam logic [AW:0]   c_depth   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   c_ptr_one = (AW+1)'(1);
  localparam logic [PW-1:0] c_pos_cap = PW'(MAX_PKT_WORDS - 1);
  localparam logic [PW-1:0] c_pos_one = PW'(1);
  localparam logic [3:0]    c_ipg     = 4'(IPG_CYCLES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_t;

  logic [32:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_spec, r_wr_commit, r_rd, r_pkt_avail;
  logic [PW-1:0] r_pos;
  logic          r_drop, r_commit_pend, r_host_ready, r_err_runt, r_err_ovf;
  state_t        r_state, w_state_nxt;
  logic [3:0]    r_gap, w_gap_nxt;
  logic [31:0]   r_tx_data, w_tx_data_nxt;
  logic          r_tx_sop, r_tx_eop, w_sop_nxt, w_eop_nxt, w_pop, w_launch;
  logic [15:0]   r_pkt_cnt;

  logic          w_acc, w_runt, w_wr, w_cap, w_close, w_ovf, w_drop_nxt;
  logic [AW:0]   w_wr_spec_nxt, w_rd_nxt;
  logic [32:0]   w_rd_word;

  assign w_acc         = bus.host_valid & r_host_ready;
  assign w_runt        = w_acc & ~r_drop & (r_pos == '0) & bus.host_last;
  assign w_wr          = w_acc & ~r_drop & ~w_runt;
  assign w_cap         = (r_pos == c_pos_cap);
  assign w_close       = w_wr & (bus.host_last | w_cap);
  assign w_ovf         = w_wr & w_cap & ~bus.host_last;
  assign w_drop_nxt    = r_drop ? ~(w_acc & bus.host_last) : w_ovf;
  assign w_wr_spec_nxt = w_runt ? r_wr_commit : (w_wr ? r_wr_spec + c_ptr_one : r_wr_spec);
  assign w_rd_nxt      = w_pop ? r_rd + c_ptr_one : r_rd;
  assign w_rd_word     = r_mem[r_rd[AW-1:0]];

  // A word reaching the length cap is stored as the packet's last word.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_spec[AW-1:0]] <= {bus.host_last | w_cap, bus.host_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_spec     <= '0;
      r_wr_commit   <= '0;
      r_rd          <= '0;
      r_pkt_avail   <= '0;
      r_pos         <= '0;
      r_drop        <= 1'b0;
      r_commit_pend <= 1'b0;
      r_host_ready  <= 1'b0;
      r_err_runt    <= 1'b0;
      r_err_ovf     <= 1'b0;
    end else begin
      r_wr_spec     <= w_wr_spec_nxt;
      r_rd          <= w_rd_nxt;
      r_drop        <= w_drop_nxt;
      r_commit_pend <= w_close;
      r_err_runt    <= w_runt;
      r_err_ovf     <= w_ovf;
      r_host_ready  <= ((w_wr_spec_nxt - w_rd_nxt) != c_depth) | w_drop_nxt;
      if (w_close) begin
        r_wr_commit <= r_wr_spec + c_ptr_one;
        r_pos       <= '0;
      end else if (w_wr) begin
        r_pos <= r_pos + c_pos_one;
      end
      // Commit is seen by the reader one cycle after the closing word.
      case ({r_commit_pend, w_launch})
        2'b10:   r_pkt_avail <= r_pkt_avail + c_ptr_one;
        2'b01:   r_pkt_avail <= r_pkt_avail - c_ptr_one;
        default: r_pkt_avail <= r_pkt_avail;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gap_nxt     = r_gap;
    w_pop         = 1'b0;
    w_launch      = 1'b0;
    w_tx_data_nxt = '0;
    w_sop_nxt     = 1'b0;
    w_eop_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_pkt_avail != '0) && !bus.tx_stall) begin
          w_launch      = 1'b1;
          w_pop         = 1'b1;
          w_sop_nxt     = 1'b1;
          w_tx_data_nxt = w_rd_word[31:0];
          w_eop_nxt     = w_rd_word[32];
          w_state_nxt   = w_rd_word[32] ? S_GAP : S_SEND;
          w_gap_nxt     = c_ipg;
        end
      end
      S_SEND: begin
        w_pop         = 1'b1;
        w_tx_data_nxt = w_rd_word[31:0];
        w_eop_nxt     = w_rd_word[32];
        if (w_rd_word[32]) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = c_ipg;
        end
      end
      S_GAP: begin
        if (r_gap == '0) w_state_nxt = S_IDLE;
        else             w_gap_nxt   = r_gap - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_gap     <= '0;
      r_tx_data <= '0;
      r_tx_sop  <= 1'b0;
      r_tx_eop  <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap     <= w_gap_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tx_sop  <= w_sop_nxt;
      r_tx_eop  <= w_eop_nxt;
      r_pkt_cnt <= r_pkt_cnt + 16'(w_eop_nxt);
    end
  end

  assign bus.host_ready   = r_host_ready;
  assign bus.tx_data      = r_tx_data;
  assign bus.tx_sop       = r_tx_sop;
  assign bus.tx_eop       = r_tx_eop;
  assign bus.tx_pkt_cnt   = r_pkt_cnt;
  assign bus.err_runt     = r_err_runt;
  assign bus.err_oversize = r_err_ovf;
endmodule
`default_nettype wire
